// File: rtl/draw_scheduler_pkg.sv
// Shared constants and state encoding for the VGA draw scheduler.
package draw_pkg;

  localparam int unsigned SCREEN_W     = 160;
  localparam int unsigned SCREEN_H     = 120;
  localparam int unsigned COLOUR_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } sched_state_t;

endpackage

// File: rtl/draw_scheduler_rr_pick.sv
// Combinational round-robin selector: first set req bit after 'last', wrapping modulo N.
module rr_pick #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    int unsigned j;
    j     = 0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      j = (int'(last) + k) % N;
      if (!valid && req[j]) begin
        idx   = IW'(j);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Shares the VGA adapter pixel-write port between N drawing engines,
// one grant at a time, with a watchdog and one idle gap cycle per release.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned COLOUR_W = draw_pkg::COLOUR_W_DEF,
  parameter int unsigned TIMEOUT  = 20000,
  parameter int unsigned SCREEN_W = draw_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H = draw_pkg::SCREEN_H
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          done,
  input  logic [N*8-1:0]        in_x,
  input  logic [N*7-1:0]        in_y,
  input  logic [N*COLOUR_W-1:0] in_colour,
  output logic [N-1:0]          enable,
  output logic [7:0]            vga_x,
  output logic [6:0]            vga_y,
  output logic [COLOUR_W-1:0]   colour,
  output logic                  plot,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  sched_state_t        state_q, state_d;
  logic [IW-1:0]       g_q, last_q;
  logic [WD_W-1:0]     wd_q;
  logic [IW-1:0]       pick_idx;
  logic                pick_valid;
  logic                wd_expire;
  logic [7:0]          sel_x;
  logic [6:0]          sel_y;
  logic [COLOUR_W-1:0] sel_colour;
  logic                sel_done;
  logic                in_range;

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .last  (last_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    sel_done   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (IW'(i) == g_q) begin
        sel_x      = in_x[i*8 +: 8];
        sel_y      = in_y[i*7 +: 7];
        sel_colour = in_colour[i*COLOUR_W +: COLOUR_W];
        sel_done   = done[i];
      end
    end
  end

  assign in_range  = (sel_x < 8'(SCREEN_W)) && (sel_y < 7'(SCREEN_H));
  assign wd_expire = (wd_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = GRANT;
      GRANT:   if (sel_done || wd_expire) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    enable = '0;
    if (state_q == GRANT) enable[g_q] = 1'b1;
  end

  assign busy = (state_q == GRANT);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      g_q         <= '0;
      last_q      <= IW'(N - 1);
      wd_q        <= '0;
      vga_x       <= '0;
      vga_y       <= '0;
      colour      <= '0;
      plot        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      plot        <= 1'b0;
      timeout_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            g_q  <= pick_idx;
            wd_q <= '0;
          end
        end
        GRANT: begin
          wd_q        <= wd_q + 1'b1;
          vga_x       <= sel_x;
          vga_y       <= sel_y;
          colour      <= sel_colour;
          plot        <= ~sel_done & in_range;
          // done on the expiry cycle is a clean release, not an error
          timeout_err <= ~sel_done & wd_expire;
        end
        GAP:     last_q <= g_q;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
- Round-robin arbiter and sequencer that shares the single VGA adapter pixel-write port between N drawing engines.
- Engines include full-screen image drawers (win/lose/background) and sprite drawers (pac-man, ghosts).
- Grants one engine at a time via its enable, muxes that engine's x/y/colour onto the adapter bus, and generates plot.
- Holds each grant until the engine's done pulse or a watchdog timeout, then inserts one idle gap cycle.

Parameters:
- N, 4, number of requesting draw engines (2..8).
- COLOUR_W, 3, pixel colour width; 1-bit engines are zero-extended by the instantiating module.
- TIMEOUT, 20000, maximum cycles a grant is held before forced release (a full 160x120 frame takes about 19.5k cycles).
- SCREEN_W, 160, visible width in pixels.
- SCREEN_H, 120, visible height in pixels.

Ports:
- clk  input  1  system clock
- resetn  input  1  synchronous active-low reset
- req  input  N  per-engine draw request, level
- done  input  N  per-engine completion pulse
- in_x  input  N*8  packed engine x coordinates, engine i at [8i+7:8i]
- in_y  input  N*7  packed engine y coordinates
- in_colour  input  N*COLOUR_W  packed engine colours
- enable  output  N  one-hot grant, drives engine enable
- vga_x  output  8  registered pixel x to adapter
- vga_y  output  7  registered pixel y to adapter
- colour  output  COLOUR_W  registered pixel colour
- plot  output  1  registered adapter write strobe
- busy  output  1  high while any grant is held
- timeout_err  output  1  one-cycle pulse on watchdog release

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-low (resetn).
- Reset values:
  - Outputs: enable=0, vga_x=0, vga_y=0, colour=0, plot=0, busy=0, timeout_err=0.
  - Internal: state=IDLE, last=N-1 (so engine 0 wins first), watchdog=0.
  - Reset mid-grant drops the grant on the same edge. Engines are reset by the same resetn.
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - If req != 0, select the first set req bit scanning from last+1 upward, wrapping modulo N.
  - Register the selected index as g, set enable to one-hot(g), clear watchdog, go to GRANT.
  - Otherwise stay in IDLE.
  - Grant appears one cycle after req is seen.
- GRANT:
  - enable[g]=1 and busy=1; watchdog increments every cycle.
  - If done[g]=1, go to GAP.
  - Else if watchdog == TIMEOUT-1, go to GAP and pulse timeout_err for one cycle.
  - If done and timeout occur on the same cycle, done wins and there is no error.
  - Deassertion of req[g] during GRANT is ignored; the grant is held until done or timeout.
  - done from non-granted engines is ignored.
- GAP:
  - enable=0, busy=0, last<=g, go to IDLE next cycle.
  - The gap guarantees the engine sees enable low after done.
  - Minimum spacing between grants is 2 idle cycles (GAP + IDLE).
- Pixel path (1-cycle pipeline matching the engines' ROM read latency):
  - vga_x, vga_y and colour register in_x/in_y/in_colour of engine g every cycle in GRANT.
  - plot <= (state==GRANT) & ~done[g] & (in_x < SCREEN_W) & (in_y < SCREEN_H).
  - Out-of-range coordinates (e.g. x=160 on a row-wrap cycle) produce plot=0.
  - Outside GRANT: plot=0 and the coordinate/colour registers hold their values.
- Widths:
  - Watchdog width is $clog2(TIMEOUT+1).
  - Index width is $clog2(N), minimum 1.
  - Round-robin wrap uses modulo N, not power of 2.
- Fairness: with all req held high, grants cycle 0,1,...,N-1,0.

Decomposition:
- Shared package draw_pkg holds:
  - SCREEN_W and SCREEN_H constants.
  - Colour width constant.
  - State enum for IDLE/GRANT/GAP.
- One natural sub-module, rr_pick:
  - Combinational round-robin selector.
  - Inputs: req and last. Outputs: index and valid.
  - Reusable by the ghost-move scheduler.
- Pixel mux and FSM stay in draw_scheduler.

Test Plan:
- Single request:
  - Stimulus: reset, then req=0001 with engine 0 pulsing done after 10 cycles.
  - Required: enable=0001 one cycle after req; 9 plots with registered coordinates; enable=0000 in GAP; busy falls.
- Round-robin:
  - Stimulus: req=1111 held, every engine pulses done 5 cycles after its enable.
  - Required: grant order 0,1,2,3,0; every grant separated by 2 enable-low cycles.
- Out-of-range pixels:
  - Stimulus: granted engine drives x=160, y=5 for one cycle, then x=159, y=119.
  - Required: plot=0 on the first, plot=1 with vga_x=159, vga_y=119 one cycle later.
- Watchdog (TIMEOUT=50 build):
  - Stimulus: granted engine never asserts done.
  - Required: release after 50 GRANT cycles; timeout_err high for exactly one cycle; next requester granted.
  - Done coinciding with the timeout cycle yields no error pulse.
- Reset mid-grant:
  - Stimulus: resetn=0 for one cycle during engine 2's grant.
  - Required: enable=0, plot=0 next edge; after release with req=0100 still high, engine 2 is granted (last=N-1 gives scan start 0, first set bit is 2).
- Ignored signals:
  - Stimulus: done[1] pulses while engine 3 is granted, and req[3] drops mid-grant.
  - Required: grant stays on engine 3 until done[3].
